cpu_step_ctrl: RTL and testbench
================================

// Module: cpu_step_ctrl
// PURPOSE
//  Synthesisable clock-enable and reset sequencer for the PipeLine CPU core.
//  Replaces hand-toggled clock/reset stimulus: holds the core in reset for a set number of cycles,
//  then advances it free-running, one debounced step per button press, or an exact burst of N cycles.
//  Sits between board clock/reset/buttons and PipeLine; its cycle counter feeds the led display mux.
// PARAMETERS
//  RST_CYCLES   4   cycles cpu_rst is held high after rst deassert or soft_rst (>=1)
//  DEB_CYCLES   16  consecutive stable cycles needed to accept a step_btn level change (>=1)
//  BURST_W      16  width of burst_len
//  CNT_W        32  width of cycle_count
// PORTS
//  clk          in   1        system clock; all logic on rising edge
//  rst          in   1        asynchronous, active-high reset
//  soft_rst     in   1        sync pulse: restart reset sequence, clear counter, abort any mode
//  mode         in   2        00 halt, 01 free-run, 10 single-step, 11 burst
//  step_btn     in   1        raw, asynchronous push button (active high)
//  start        in   1        sync pulse: launch a burst (mode 11 only)
//  burst_len    in   BURST_W  cycles to run in burst; sampled on start
//  cpu_rst      out  1        reset to CPU core, active high
//  cpu_clk_en   out  1        CPU clock enable; core advances one cycle per high cycle
//  cycle_count  out  CNT_W    number of cpu_clk_en cycles since last reset
//  busy         out  1        high when state != IDLE
//  done         out  1        one-cycle pulse at burst completion
// BEHAVIOUR
//  Reset (rst high): state=HOLD, cpu_rst=1, cpu_clk_en=0, cycle_count=0, busy=1, done=0,
//   hold counter=0, debouncer synchroniser/state=0, remaining=0.
//  All outputs are registered; every decision below appears on the outputs one cycle after its cause.
//  States: HOLD, IDLE, RUN, BURST.
//  HOLD: cpu_rst=1, cpu_clk_en=0. Counts RST_CYCLES clocks after rst deasserts.
//   - The clock after the count is reached: -> IDLE, cpu_rst=0.
//  soft_rst (any state, highest priority over all other inputs):
//   - -> HOLD, hold counter=0, cycle_count=0, cpu_clk_en=0 next cycle, no done pulse.
//  Debouncer:
//   - step_btn passes a 2-flop synchroniser.
//   - The filtered level btn_db changes only after the synchronised level differs from btn_db
//     for DEB_CYCLES consecutive cycles. Any bounce restarts the count.
//   - A btn_db 0->1 edge gives a one-cycle step_req. Edges taken while not in IDLE/mode 10 are discarded.
//  IDLE (cpu_clk_en=0 unless stepping):
//   - mode 01: -> RUN.
//   - mode 10 with step_req: cpu_clk_en=1 for exactly one cycle; stay IDLE.
//   - mode 11 with start: remaining=burst_len.
//     - burst_len=0: done=1 for one cycle, stay IDLE, no enable.
//     - otherwise: -> BURST.
//   - mode 00, or start in a mode other than 11: no effect.
//  RUN: cpu_clk_en=1 every cycle while mode==01.
//   - When mode!=01 is sampled: -> IDLE, and cpu_clk_en is 0 from the next cycle.
//  BURST: cpu_clk_en=1 for exactly burst_len consecutive cycles; remaining decrements per enable.
//   - Cycle after the last enable: done=1, -> IDLE.
//   - mode and start are ignored during BURST; only soft_rst/rst abort it.
//  cycle_count: +1 on each cycle cpu_clk_en=1; wraps 2^CNT_W-1 -> 0 with no flag.
//  rst mid-operation: immediate asynchronous return to reset values. cpu_rst rises asynchronously.
// TESTING
//  1 Reset: rst high 3 cycles, then low -> cpu_rst high for exactly 4 clocks, then low; busy 1->0.
//  2 Free-run: mode=01 for 10 cycles, then 00 -> exactly 10 cpu_clk_en cycles; cycle_count=10.
//  3 Step: mode=10; btn bounces 1/0 every 3 cycles for 30 cycles, then holds high 20, low 20
//    -> exactly one cpu_clk_en pulse; cycle_count +1.
//  4 Burst: mode=11, burst_len=5, start pulse -> 5 consecutive enables; done pulses the next cycle;
//    burst_len=0 -> done only, no enable.
//  5 Abort: soft_rst on burst cycle 3 -> enables stop next cycle; cpu_rst held 4 cycles;
//    cycle_count=0; no done pulse.
//  6 Wrap: CNT_W=4, free-run 17 cycles -> cycle_count=1.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - clock-enable and reset sequencer for the PipeLine CPU core
//
// Holds the core in reset for RST_CYCLES clocks, then advances it in one of
// four modes: halt, free-run, debounced single-step, or an exact N-cycle burst.
// Every output is registered, so each decision is visible one cycle after its cause.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   soft_rst_i     sync pulse: restart reset sequence, clear counter, abort any mode
//   mode_i         00 halt, 01 free-run, 10 single-step, 11 burst
//   step_btn_i     raw asynchronous push button, active high
//   start_i        sync pulse: launch a burst (mode 11 only)
//   burst_len_i    burst length, sampled on start_i
//   cpu_rst_o      reset to the CPU core, active high
//   cpu_clk_en_o   CPU clock enable, one core cycle per high cycle
//   cycle_count_o  number of enabled cycles since last reset (wraps silently)
//   busy_o         high whenever the sequencer is not idle
//   done_o         one-cycle pulse at burst completion
module cpu_step_ctrl #(
    parameter int RST_CYCLES = 4,
    parameter int DEB_CYCLES = 16,
    parameter int BURST_W    = 16,
    parameter int CNT_W      = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               soft_rst_i,
    input  logic [1:0]         mode_i,
    input  logic               step_btn_i,
    input  logic               start_i,
    input  logic [BURST_W-1:0] burst_len_i,
    output logic               cpu_rst_o,
    output logic               cpu_clk_en_o,
    output logic [CNT_W-1:0]   cycle_count_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_IDLE,
        ST_RUN,
        ST_BURST
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [BURST_W-1:0]  remaining_q, remaining_d;
    logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
    logic                cpu_rst_q;
    logic                cpu_clk_en_q, cpu_clk_en_d;
    logic                busy_q;
    logic                done_q, done_d;

    logic                sync1_q, sync2_q;
    logic                btn_db_q, btn_db_d;
    logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
    logic                step_req;

    // Debouncer: the filtered level follows the synchronised button only after
    // it has disagreed for DEB_CYCLES consecutive cycles; any agreement clears
    // the run length.
    always_comb begin
        btn_db_d  = btn_db_q;
        deb_cnt_d = '0;
        if (sync2_q != btn_db_q) begin
            if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                btn_db_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // High for the single cycle in which the filtered level is about to rise.
    assign step_req = btn_db_d & ~btn_db_q;

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        remaining_d  = remaining_q;
        cpu_clk_en_d = 1'b0;
        done_d       = 1'b0;

        if (soft_rst_i) begin
            state_d     = ST_HOLD;
            hold_cnt_d  = '0;
            remaining_d = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
                        state_d    = ST_IDLE;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                ST_IDLE: begin
                    case (mode_i)
                        // The sampling cycle already counts as the first free-run
                        // cycle, so N cycles of mode 01 give N enables.
                        MODE_RUN: begin
                            state_d      = ST_RUN;
                            cpu_clk_en_d = 1'b1;
                        end
                        MODE_STEP: begin
                            cpu_clk_en_d = step_req;
                        end
                        MODE_BURST: begin
                            if (start_i) begin
                                if (burst_len_i == '0) begin
                                    done_d = 1'b1;
                                end else begin
                                    // First enable issues now; remaining holds
                                    // the enables still owed after this one.
                                    state_d      = ST_BURST;
                                    cpu_clk_en_d = 1'b1;
                                    remaining_d  = burst_len_i - BURST_W'(1);
                                end
                            end
                        end
                        default: ;
                    endcase
                end
                ST_RUN: begin
                    if (mode_i == MODE_RUN) begin
                        cpu_clk_en_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (remaining_q != '0) begin
                        cpu_clk_en_d = 1'b1;
                        remaining_d  = remaining_q - BURST_W'(1);
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end

        if (soft_rst_i) begin
            cycle_count_d = '0;
        end else begin
            cycle_count_d = cycle_count_q + CNT_W'(cpu_clk_en_d);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_HOLD;
            hold_cnt_q    <= '0;
            remaining_q   <= '0;
            cycle_count_q <= '0;
            cpu_rst_q     <= 1'b1;
            cpu_clk_en_q  <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            btn_db_q      <= 1'b0;
            deb_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            remaining_q   <= remaining_d;
            cycle_count_q <= cycle_count_d;
            cpu_rst_q     <= (state_d == ST_HOLD);
            cpu_clk_en_q  <= cpu_clk_en_d;
            busy_q        <= (state_d != ST_IDLE);
            done_q        <= done_d;
            sync1_q       <= step_btn_i;
            sync2_q       <= sync1_q;
            btn_db_q      <= btn_db_d;
            deb_cnt_q     <= deb_cnt_d;
        end
    end

    assign cpu_rst_o     = cpu_rst_q;
    assign cpu_clk_en_o  = cpu_clk_en_q;
    assign cycle_count_o = cycle_count_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - self-checking bench for cpu_step_ctrl
module tb_cpu_step_ctrl;

    localparam int RST_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        soft_rst = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        step_btn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] burst_len = '0;

    logic        cpu_rst, cpu_en, busy, done;
    logic [31:0] cnt;
    logic        cpu_rst4, cpu_en4, busy4, done4;
    logic [3:0]  cnt4;

    cpu_step_ctrl #(.RST_CYCLES(RST_CYCLES), .DEB_CYCLES(16), .BURST_W(16), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .soft_rst_i(soft_rst), .mode_i(mode),
        .step_btn_i(step_btn), .start_i(start), .burst_len_i(burst_len),
        .cpu_rst_o(cpu_rst), .cpu_clk_en_o(cpu_en), .cycle_count_o(cnt),
        .busy_o(busy), .done_o(done)
    );

    cpu_step_ctrl #(.RST_CYCLES(RST_CYCLES), .DEB_CYCLES(16), .BURST_W(16), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .soft_rst_i(soft_rst), .mode_i(mode),
        .step_btn_i(step_btn), .start_i(start), .burst_len_i(burst_len),
        .cpu_rst_o(cpu_rst4), .cpu_clk_en_o(cpu_en4), .cycle_count_o(cnt4),
        .busy_o(busy4), .done_o(done4)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: reset window length, a schedule of future burst
    // cycles (1 = enable, 2 = done), a free-run flag and an enable tally.
    bit          m_in_reset;
    int          m_hold_n;
    bit          m_running;
    int          m_sched[$];
    bit          m_en, m_done;
    logic [31:0] m_count;
    bit          step_phase = 1'b0;
    int          step_pulses;

    task automatic model_reset();
        m_in_reset = 1'b1;
        m_hold_n   = 0;
        m_running  = 1'b0;
        m_sched.delete();
        m_en       = 1'b0;
        m_done     = 1'b0;
        m_count    = '0;
    endtask

    task automatic model_step();
        int e;
        m_en   = 1'b0;
        m_done = 1'b0;
        if (rst) begin
            model_reset();
        end else if (soft_rst) begin
            model_reset();
        end else if (m_in_reset) begin
            m_hold_n++;
            if (m_hold_n == RST_CYCLES) m_in_reset = 1'b0;
        end else if (m_sched.size() > 0) begin
            e = m_sched.pop_front();
            if (e == 1) m_en = 1'b1;
            else m_done = 1'b1;
        end else if (m_running) begin
            if (mode == 2'b01) m_en = 1'b1;
            else m_running = 1'b0;
        end else begin
            if (mode == 2'b01) begin
                m_running = 1'b1;
                m_en      = 1'b1;
            end else if (mode == 2'b11 && start) begin
                if (burst_len == 0) begin
                    m_done = 1'b1;
                end else begin
                    m_en = 1'b1;
                    repeat (int'(burst_len) - 1) m_sched.push_back(1);
                    m_sched.push_back(2);
                end
            end
        end
        m_count = m_count + 32'(m_en);
    endtask

    task automatic check_all();
        bit exp_busy;
        exp_busy = m_in_reset || (m_sched.size() > 0) || m_running;
        expect_eq("cpu_rst", 32'(cpu_rst), 32'(m_in_reset));
        expect_eq("busy", 32'(busy), 32'(exp_busy));
        expect_eq("done", 32'(done), 32'(m_done));
        if (!step_phase) begin
            expect_eq("clk_en", 32'(cpu_en), 32'(m_en));
            expect_eq("count", cnt, m_count);
            expect_eq("count4", 32'(cnt4), 32'(m_count[3:0]));
        end else if (cpu_en) begin
            step_pulses++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    int hold_seen, en_seen, done_seen;

    initial begin
        rst = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #2;
        expect_eq("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        expect_eq("rst_en", 32'(cpu_en), 32'd0);
        expect_eq("rst_count", cnt, 32'd0);
        expect_eq("rst_busy", 32'(busy), 32'd1);
        expect_eq("rst_done", 32'(done), 32'd0);

        // Reset release: cpu_rst spans exactly RST_CYCLES clock periods
        repeat (3) tick();
        rst = 1'b0;
        #1;
        hold_seen = cpu_rst ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cpu_rst) hold_seen++;
        end
        expect_eq("hold_len", 32'(hold_seen), 32'(RST_CYCLES));

        // Free-run for 10 sampled cycles
        mode = 2'b01;
        repeat (10) tick();
        mode = 2'b00;
        repeat (3) tick();
        expect_eq("freerun_cnt", cnt, 32'd10);

        // Single step through a bouncing button, then a clean press
        step_phase  = 1'b1;
        step_pulses = 0;
        mode = 2'b10;
        for (int i = 0; i < 30; i++) begin
            step_btn = ((i / 3) % 2) == 0;
            tick();
        end
        step_btn = 1'b0;
        repeat (20) tick();
        expect_eq("bounce_pulses", 32'(step_pulses), 32'd0);
        step_btn = 1'b1;
        repeat (20) tick();
        step_btn = 1'b0;
        repeat (25) tick();
        expect_eq("step_pulses", 32'(step_pulses), 32'd1);
        expect_eq("step_cnt", cnt, 32'd11);
        // A press in halt mode is discarded
        mode = 2'b00;
        step_btn = 1'b1;
        repeat (20) tick();
        step_btn = 1'b0;
        repeat (25) tick();
        expect_eq("halt_press", 32'(step_pulses), 32'd1);
        step_phase = 1'b0;
        m_count = m_count + 32'd1;

        // Burst of 5, then a zero-length burst
        mode = 2'b11;
        burst_len = 16'd5;
        start = 1'b1;
        en_seen = 0;
        done_seen = 0;
        tick();
        start = 1'b0;
        if (cpu_en) en_seen++;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cpu_en) en_seen++;
            if (done) done_seen++;
        end
        expect_eq("burst5_en", 32'(en_seen), 32'd5);
        expect_eq("burst5_done", 32'(done_seen), 32'd1);
        burst_len = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_eq("burst0_done", 32'(done), 32'd1);
        expect_eq("burst0_en", 32'(cpu_en), 32'd0);
        repeat (2) tick();

        // Abort a burst on its third enable
        burst_len = 16'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        expect_eq("abort_pre_en", 32'(cpu_en), 32'd1);
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        mode = 2'b00;
        expect_eq("abort_en", 32'(cpu_en), 32'd0);
        expect_eq("abort_cnt", cnt, 32'd0);
        hold_seen = cpu_rst ? 1 : 0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cpu_rst) hold_seen++;
            if (done) done_seen++;
        end
        expect_eq("abort_hold", 32'(hold_seen), 32'd4);
        expect_eq("abort_done", 32'(done_seen), 32'd0);

        // Wrap of the 4-bit counter after 17 free-run cycles
        mode = 2'b01;
        repeat (17) tick();
        mode = 2'b00;
        repeat (2) tick();
        expect_eq("wrap_cnt4", 32'(cnt4), 32'd1);
        expect_eq("wrap_cnt", cnt, 32'd17);

        // Randomised mode/start/soft_rst traffic against the model
        for (int i = 0; i < 3000; i++) begin
            soft_rst = ($urandom_range(0, 119) == 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
            start = ($urandom_range(0, 4) == 0);
            burst_len = 16'($urandom_range(0, 9));
            tick();
        end
        soft_rst = 1'b0;
        start = 1'b0;

        // Asynchronous reset in the middle of free-run
        mode = 2'b01;
        repeat (RST_CYCLES + 6) tick();
        #2 rst = 1'b1;
        #1;
        model_reset();
        expect_eq("arst_cpu_rst", 32'(cpu_rst), 32'd1);
        expect_eq("arst_en", 32'(cpu_en), 32'd0);
        expect_eq("arst_cnt", cnt, 32'd0);
        expect_eq("arst_busy", 32'(busy), 32'd1);
        repeat (2) tick();
        rst = 1'b0;
        repeat (RST_CYCLES + 6) tick();
        mode = 2'b00;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
